mcb_frame_sched: RTL and testbench

MCB_FRAME_SCHED -- requirements
Module: mcb_frame_sched

---
 rtl/mcb_frame_sched.sv | 164 ++++++++++++++++
 tb/tb_mcb_frame_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_frame_sched.sv
// Frame-slot scheduler between an MCB frame writer and a frame reader.
// It hands the reader the newest completed slot and tracks drops, repeats, overruns and writer stalls.
module mcb_frame_sched #(
   parameter int C_ADDR_WIDTH = 30,
   parameter int ADDR_NUM     = 8,
   parameter int FRAME_SHIFT  = 24,
   parameter int START_FRAMES = 3,
   parameter int WD_CYCLES    = 2**24
) (
   input  logic                    reset,
   input  logic                    mcb_clk,
   input  logic [C_ADDR_WIDTH-1:0] wr_addr,
   input  logic                    wr_addr_valid,
   input  logic                    rd_frame_req,
   input  logic                    rd_frame_done,
   output logic                    rd_enable,
   output logic [C_ADDR_WIDTH-1:0] rd_base_addr,
   output logic                    rd_base_valid,
   output logic                    wr_stall,
   output logic                    overrun_err,
   output logic [15:0]             drop_cnt,
   output logic [15:0]             repeat_cnt
);

   localparam int SLOT_W = $clog2(ADDR_NUM);
   localparam int FILL_W = $clog2(ADDR_NUM);
   localparam int WD_W   = $clog2(WD_CYCLES + 1);

   localparam logic [FILL_W:0]   START_C = (FILL_W+1)'(START_FRAMES);
   localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(WD_CYCLES);

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              have_wr_q, have_wr_d;
   logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
   logic [SLOT_W-1:0] last_done_q, last_done_d;
   logic              fresh_q, fresh_d;
   logic [FILL_W:0]   fill_cnt_q, fill_cnt_d;
   logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
   logic              rd_busy_q, rd_busy_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overrun_q, overrun_d;
   logic [15:0]       drop_q, drop_d;
   logic [15:0]       repeat_q, repeat_d;
   logic [WD_W-1:0]   wd_q, wd_d;

   logic [SLOT_W-1:0] wr_slot_in;
   logic              completes;
   logic              grant;
   logic [SLOT_W-1:0] last_done_byp;
   logic              fresh_byp;
   logic              addr_unused;

   assign wr_slot_in  = wr_addr[FRAME_SHIFT +: SLOT_W];
   assign addr_unused = ^wr_addr;

   always_comb begin
      // A pulse completes the previous frame only once the writer has started one
      completes     = wr_addr_valid & have_wr_q;
      grant         = rd_frame_req & (state_q != S_FILL);
      last_done_byp = completes ? wr_slot_q : last_done_q;
      fresh_byp     = completes | fresh_q;

      state_d     = state_q;
      have_wr_d   = have_wr_q | wr_addr_valid;
      wr_slot_d   = wr_addr_valid ? wr_slot_in : wr_slot_q;
      last_done_d = last_done_byp;
      fresh_d     = fresh_byp;
      fill_cnt_d  = fill_cnt_q;
      rd_slot_d   = rd_slot_q;
      rd_busy_d   = rd_busy_q;
      rd_valid_d  = grant;
      overrun_d   = overrun_q;
      drop_d      = drop_q;
      repeat_d    = repeat_q;
      wd_d        = wr_addr_valid ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + 1'b1);

      // A frame overwritten before the reader took it is a drop, unless taken this very cycle
      if (completes && fresh_q && !grant && drop_q != 16'hFFFF)
         drop_d = drop_q + 16'd1;

      if (grant) begin
         rd_busy_d = 1'b1;
         if (fresh_byp) begin
            rd_slot_d = last_done_byp;
            fresh_d   = 1'b0;
         end else if (repeat_q != 16'hFFFF) begin
            repeat_d = repeat_q + 16'd1;
         end
      end else if (rd_frame_done) begin
         rd_busy_d = 1'b0;
      end

      if (wr_addr_valid && rd_busy_q && wr_slot_in == rd_slot_q)
         overrun_d = 1'b1;

      case (state_q)
         S_FILL: begin
            if (completes) begin
               fill_cnt_d = fill_cnt_q + 1'b1;
               if (fill_cnt_q + 1'b1 == START_C)
                  state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (wd_d == WD_MAX)
               state_d = S_STALL;
         end
         S_STALL: begin
            if (wr_addr_valid)
               state_d = S_RUN;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge mcb_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FILL;
         have_wr_q   <= 1'b0;
         wr_slot_q   <= '0;
         last_done_q <= '0;
         fresh_q     <= 1'b0;
         fill_cnt_q  <= '0;
         rd_slot_q   <= '0;
         rd_busy_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         drop_q      <= '0;
         repeat_q    <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         have_wr_q   <= have_wr_d;
         wr_slot_q   <= wr_slot_d;
         last_done_q <= last_done_d;
         fresh_q     <= fresh_d;
         fill_cnt_q  <= fill_cnt_d;
         rd_slot_q   <= rd_slot_d;
         rd_busy_q   <= rd_busy_d;
         rd_valid_q  <= rd_valid_d;
         overrun_q   <= overrun_d;
         drop_q      <= drop_d;
         repeat_q    <= repeat_d;
         wd_q        <= wd_d;
      end
   end

   always_comb begin
      rd_base_addr = '0;
      rd_base_addr[FRAME_SHIFT +: SLOT_W] = rd_slot_q;
   end

   assign rd_enable     = (state_q != S_FILL);
   assign wr_stall      = (state_q == S_STALL);
   assign rd_base_valid = rd_valid_q;
   assign overrun_err   = overrun_q;
   assign drop_cnt      = drop_q;
   assign repeat_cnt    = repeat_q;

endmodule

// File: tb/tb_mcb_frame_sched.sv
// Bench for mcb_frame_sched: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the slot scheduling rules.
module tb_mcb_frame_sched;

   localparam int AW    = 30;
   localparam int SHIFT = 24;
   localparam int START = 3;
   localparam int WD    = 16;

   logic          reset;
   logic          mcb_clk;
   logic [AW-1:0] wr_addr;
   logic          wr_addr_valid;
   logic          rd_frame_req;
   logic          rd_frame_done;
   logic          rd_enable;
   logic [AW-1:0] rd_base_addr;
   logic          rd_base_valid;
   logic          wr_stall;
   logic          overrun_err;
   logic [15:0]   drop_cnt;
   logic [15:0]   repeat_cnt;

   int checks = 0;
   int errors = 0;

   // Behavioural model: plain counters and flags, one update per clock
   bit m_started, m_fresh, m_busy, m_ovr, m_valid, m_enabled, m_stalled;
   int m_wslot, m_last, m_rslot, m_frames, m_drop, m_rep, m_idle;

   mcb_frame_sched #(
      .C_ADDR_WIDTH (AW),
      .ADDR_NUM     (8),
      .FRAME_SHIFT  (SHIFT),
      .START_FRAMES (START),
      .WD_CYCLES    (WD)
   ) dut (
      .reset         (reset),
      .mcb_clk       (mcb_clk),
      .wr_addr       (wr_addr),
      .wr_addr_valid (wr_addr_valid),
      .rd_frame_req  (rd_frame_req),
      .rd_frame_done (rd_frame_done),
      .rd_enable     (rd_enable),
      .rd_base_addr  (rd_base_addr),
      .rd_base_valid (rd_base_valid),
      .wr_stall      (wr_stall),
      .overrun_err   (overrun_err),
      .drop_cnt      (drop_cnt),
      .repeat_cnt    (repeat_cnt)
   );

   initial mcb_clk = 1'b0;
   always #5 mcb_clk = ~mcb_clk;

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_started = 0; m_fresh = 0; m_busy = 0; m_ovr = 0; m_valid = 0;
      m_enabled = 0; m_stalled = 0;
      m_wslot = 0; m_last = 0; m_rslot = 0; m_frames = 0;
      m_drop = 0; m_rep = 0; m_idle = 0;
   endtask

   task automatic model_cycle(input bit wv, input int slot, input bit req, input bit done);
      bit completes;
      bit grant;
      bit was_stalled;
      completes   = wv && m_started;
      grant       = req && m_enabled;
      was_stalled = m_stalled;
      if (wv && m_busy && slot == m_rslot) m_ovr = 1;
      if (completes) begin
         if (m_fresh && !grant) m_drop = sat16(m_drop + 1);
         m_last  = m_wslot;
         m_fresh = 1;
      end
      m_valid = grant;
      if (grant) begin
         m_busy = 1;
         if (m_fresh) begin
            m_rslot = m_last;
            m_fresh = 0;
         end else begin
            m_rep = sat16(m_rep + 1);
         end
      end else if (done) begin
         m_busy = 0;
      end
      if (wv) begin
         m_wslot   = slot;
         m_started = 1;
         m_idle    = 0;
      end else begin
         m_idle++;
      end
      if (!m_enabled) begin
         if (completes) begin
            m_frames++;
            if (m_frames == START) m_enabled = 1;
         end
      end else if (was_stalled) begin
         if (wv) m_stalled = 0;
      end else if (m_idle >= WD) begin
         m_stalled = 1;
      end
   endtask

   task automatic compare_all();
      check("rd_enable",     32'(rd_enable),     32'(m_enabled));
      check("rd_base_valid", 32'(rd_base_valid), 32'(m_valid));
      check("rd_base_addr",  32'(rd_base_addr),  32'(m_rslot) << SHIFT);
      check("wr_stall",      32'(wr_stall),      32'(m_stalled));
      check("overrun_err",   32'(overrun_err),   32'(m_ovr));
      check("drop_cnt",      32'(drop_cnt),      32'(m_drop));
      check("repeat_cnt",    32'(repeat_cnt),    32'(m_rep));
   endtask

   task automatic step(input bit wv, input int slot, input bit req, input bit done);
      logic [AW-1:0] a;
      a = AW'($urandom);
      a[SHIFT +: 3] = slot[2:0];
      wr_addr       = a;
      wr_addr_valid = wv;
      rd_frame_req  = req;
      rd_frame_done = done;
      @(posedge mcb_clk);
      model_cycle(wv, slot, req, done);
      #1;
      compare_all();
      if (rd_base_valid)
         $display("grant: addr=%08h drop=%0d repeat=%0d overrun=%0d stall=%0d",
                  rd_base_addr, drop_cnt, repeat_cnt, overrun_err, wr_stall);
      wr_addr_valid = 0;
      rd_frame_req  = 0;
      rd_frame_done = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en"},    32'(rd_enable),     32'd0);
      check({tag, "_valid"}, 32'(rd_base_valid), 32'd0);
      check({tag, "_addr"},  32'(rd_base_addr),  32'd0);
      check({tag, "_stall"}, 32'(wr_stall),      32'd0);
      check({tag, "_ovr"},   32'(overrun_err),   32'd0);
      check({tag, "_drop"},  32'(drop_cnt),      32'd0);
      check({tag, "_rep"},   32'(repeat_cnt),    32'd0);
   endtask

   initial begin
      reset = 1; wr_addr = '0; wr_addr_valid = 0; rd_frame_req = 0; rd_frame_done = 0;
      model_reset();
      repeat (2) @(posedge mcb_clk);
      #1;
      check_all_zero("reset");
      reset = 0;

      // Fill: first pulse only starts a frame; a read request here is ignored
      step(1, 0, 0, 0);
      check("fill_first_en", 32'(rd_enable), 32'd0);
      step(0, 0, 1, 0);
      check("fill_req_ignored", 32'(rd_base_valid), 32'd0);
      step(1, 1, 0, 0);
      step(1, 2, 0, 0);
      check("fill_before_slot3", 32'(rd_enable), 32'd0);
      step(1, 3, 0, 0);
      check("fill_en_after_slot3", 32'(rd_enable), 32'd1);

      // Writer at slot 5 -> reader gets slot 4
      step(1, 4, 0, 0);
      step(1, 5, 0, 0);
      step(0, 0, 1, 0);
      check("grant_valid", 32'(rd_base_valid), 32'd1);
      check("grant_slot4", 32'(rd_base_addr), 32'h0400_0000);
      step(0, 0, 0, 0);
      check("addr_held", 32'(rd_base_addr), 32'h0400_0000);

      // Two writes without a read: one drop; a second read with no write repeats
      step(1, 6, 0, 0);
      step(1, 7, 0, 0);
      step(0, 0, 1, 0);
      check("drop_one", 32'(drop_cnt), 32'd5);
      check("grant_slot6", 32'(rd_base_addr), 32'h0600_0000);
      step(0, 0, 1, 0);
      check("repeat_addr", 32'(rd_base_addr), 32'h0600_0000);
      check("repeat_one", 32'(repeat_cnt), 32'd1);
      step(0, 0, 0, 1);

      // Same-cycle write (slot 6) and request: bypass grants slot 5, no drop
      step(1, 5, 0, 0);
      step(1, 6, 1, 0);
      check("bypass_slot5", 32'(rd_base_addr), 32'h0500_0000);
      check("bypass_no_drop", 32'(drop_cnt), 32'd5);
      step(0, 0, 0, 1);

      // Reader busy on slot 2, writer wraps onto it
      for (int s = 7; s < 12; s++) step(1, s % 8, 0, 0);
      step(0, 0, 1, 0);
      check("busy_slot2", 32'(rd_base_addr), 32'h0200_0000);
      for (int s = 4; s < 10; s++) step(1, s % 8, 0, 0);
      check("no_overrun_yet", 32'(overrun_err), 32'd0);
      step(1, 2, 0, 0);
      check("overrun_set", 32'(overrun_err), 32'd1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      check("overrun_sticky", 32'(overrun_err), 32'd1);

      // Asynchronous reset in the middle of a grant
      step(1, 3, 1, 0);
      reset = 1;
      #2;
      model_reset();
      check_all_zero("async_rst");
      @(posedge mcb_clk);
      #1;
      reset = 0;
      compare_all();

      // Refill after reset, then let the watchdog expire
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 2, 0, 0);
      check("refill_not_yet", 32'(rd_enable), 32'd0);
      step(1, 3, 0, 0);
      check("refill_en", 32'(rd_enable), 32'd1);
      step(0, 0, 1, 0);
      repeat (WD - 2) step(0, 0, 0, 0);
      check("wd_not_yet", 32'(wr_stall), 32'd0);
      step(0, 0, 0, 0);
      check("wd_stall", 32'(wr_stall), 32'd1);
      step(0, 0, 1, 0);
      check("stall_repeat_addr", 32'(rd_base_addr), 32'h0200_0000);
      check("stall_repeat_cnt", 32'(repeat_cnt), 32'd1);
      step(1, 4, 0, 0);
      check("stall_cleared", 32'(wr_stall), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
              $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
